// File: rtl/ux607_dlm_ctrl_pkg.sv
// Shared types and defaults for the DLM RAM front-end controller.
package ux607_dlm_ctrl_pkg;

    localparam int unsigned UX607_DLM_RAM_AW      = 12;
    localparam int unsigned UX607_DLM_RAM_DW      = 32;
    localparam int unsigned UX607_DLM_RAM_MW      = UX607_DLM_RAM_DW / 8;
    localparam int unsigned UX607_DLM_IDLE_LS_CYC = 16;

    typedef enum logic [1:0] {
        StActive,
        StSleep,
        StWake
    } ls_state_e;

endpackage

// File: rtl/ux607_dlm_rsp_fifo.sv
// In-order response FIFO; depth need not be a power of two.
module ux607_dlm_rsp_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 3,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] cnt
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop & (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        case ({push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/ux607_dlm_ctrl.sv
// Valid/ready front-end for the DLM RAM: single-cycle accesses, credited response
// FIFO and idle-driven light sleep with a one-cycle wake.
module ux607_dlm_ctrl
    import ux607_dlm_ctrl_pkg::*;
#(
    parameter int unsigned AW          = UX607_DLM_RAM_AW,
    parameter int unsigned DW          = UX607_DLM_RAM_DW,
    parameter int unsigned MW          = UX607_DLM_RAM_MW,
    parameter int unsigned RSP_DEPTH   = 3,
    parameter int unsigned IDLE_LS_CYC = UX607_DLM_IDLE_LS_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          ram_cs,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned IW = (IDLE_LS_CYC > 0) ? $clog2(IDLE_LS_CYC + 1) : 1;

    ls_state_e     state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ram_ls_q;
    logic          inflight_q, inflight_rd_q;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credits_used;
    logic          accept;
    logic          idle_cycle;

    assign credits_used = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight_q};

    // Gate with rst_n so no command is offered while reset is held.
    assign cmd_ready = rst_n & (state_q == StActive)
                     & (credits_used < (CW + 1)'(RSP_DEPTH));
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        ram_cs   = accept;
        ram_addr = '0;
        ram_wem  = '0;
        ram_din  = '0;
        if (accept) begin
            ram_addr = cmd_addr;
            ram_wem  = cmd_read ? '0 : cmd_wmask;
            ram_din  = cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            inflight_rd_q <= 1'b0;
        end else begin
            inflight_q    <= accept;
            inflight_rd_q <= accept & cmd_read;
        end
    end

    // RAM read data is only valid in the cycle after the access: capture it now.
    ux607_dlm_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (inflight_rd_q ? ram_dout : '0),
        .pop       (rsp_valid & rsp_ready),
        .head      (rsp_rdata),
        .cnt       (fifo_cnt)
    );

    assign rsp_valid = (fifo_cnt != '0);

    assign idle_cycle = ~cmd_valid & ~inflight_q & (fifo_cnt == '0);

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        unique case (state_q)
            StActive: begin
                if (!idle_cycle) begin
                    idle_d = '0;
                end else if (idle_q != IW'(IDLE_LS_CYC)) begin
                    idle_d = idle_q + 1'b1;
                end
                if ((IDLE_LS_CYC != 0) && (idle_d == IW'(IDLE_LS_CYC))) begin
                    state_d = StSleep;
                    idle_d  = '0;
                end
            end
            StSleep: begin
                idle_d = '0;
                if (cmd_valid) state_d = StWake;
            end
            StWake: begin
                idle_d  = '0;
                state_d = StActive;
            end
            default: begin
                idle_d  = '0;
                state_d = StActive;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StActive;
            idle_q   <= '0;
            ram_ls_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            ram_ls_q <= (state_d == StSleep);
        end
    end

    assign ram_ls = ram_ls_q;

endmodule

// File: tb/tb_ux607_dlm_ctrl.sv
// Randomised scoreboard bench for ux607_dlm_ctrl with a behavioural RAM and reference memory.
module tb_ux607_dlm_ctrl;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned IDLE = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          ram_cs, ram_ls;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    ux607_dlm_ctrl #(
        .AW          (AW),
        .DW          (DW),
        .MW          (MW),
        .RSP_DEPTH   (3),
        .IDLE_LS_CYC (IDLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wmask (cmd_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_cs    (ram_cs),
        .ram_addr  (ram_addr),
        .ram_wem   (ram_wem),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_ls    (ram_ls)
    );

    // Behavioural RAM: one-cycle read latency, garbage on dout otherwise.
    logic [DW-1:0] ram_mem [1 << AW];
    logic          rd_v;
    logic [DW-1:0] rd_d, junk;

    always @(posedge clk) begin
        junk <= $urandom;
        rd_v <= ram_cs && (ram_wem == '0);
        if (ram_cs) begin
            rd_d <= ram_mem[ram_addr];
            for (int i = 0; i < int'(MW); i++)
                if (ram_wem[i]) ram_mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
        end
    end
    assign ram_dout = rd_v ? rd_d : junk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [32];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            acc_count = 0;
    int            last_acc_cyc = 0;
    int            last_pop_cyc = 0;
    logic [DW-1:0] last_rsp = '0;
    logic          lat_check = 1'b0;
    logic          running;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: expected responses pushed at accept, popped at handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
                    if (lat_check) check("rsp_latency", 64'(cyc - e.cyc), 64'd2);
                    last_rsp     = rsp_rdata;
                    last_pop_cyc = cyc;
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_t e;
                check("ram_drive", {ram_cs, 3'b0, ram_addr, ram_wem, ram_din},
                      {1'b1, 3'b0, cmd_addr, cmd_read ? 4'h0 : cmd_wmask, cmd_wdata});
                if (cmd_read) begin
                    e.data = ref_mem[cmd_addr[4:0]];
                end else begin
                    for (int i = 0; i < int'(MW); i++)
                        if (cmd_wmask[i]) ref_mem[cmd_addr[4:0]][8*i +: 8] = cmd_wdata[8*i +: 8];
                    e.data = '0;
                end
                e.cyc = cyc;
                sb.push_back(e);
                acc_count++;
                last_acc_cyc = cyc;
            end else begin
                check("ram_cs_idle", 64'(ram_cs), 64'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting cycle.
    task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
        bit got = 0;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wmask = m;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, f, rise, bad;
        bit seen;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_read  = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wmask = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_ram_cs", 64'(ram_cs), 64'd0);
        check("reset_ram_ls", 64'(ram_ls), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Prefill the address window used by the bench.
        for (int i = 0; i < 32; i++) issue(1'b0, AW'(i), $urandom, 4'hF);
        drain();

        // Write then read.
        lat_check = 1'b1;
        issue(1'b0, 12'h010, 32'hDEAD_BEEF, 4'hF);
        issue(1'b1, 12'h010, '0, '0);
        drain();
        check("write_read_data", 64'(last_rsp), 64'hDEAD_BEEF);

        // Partial write.
        issue(1'b0, 12'h005, 32'hFFFF_FFFF, 4'hF);
        issue(1'b0, 12'h005, 32'h1122_3344, 4'b0101);
        issue(1'b1, 12'h005, '0, '0);
        drain();
        check("partial_write_data", 64'(last_rsp), 64'hFF22_FF44);
        lat_check = 1'b0;

        // Backpressure: three credits, then stall until a pop.
        rsp_ready = 1'b0;
        a0 = acc_count;
        for (int i = 1; i <= 3; i++) issue(1'b1, AW'(i), '0, '0);
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 12'd4;
        repeat (4) begin
            @(negedge clk);
            check("bp_ready_low", 64'(cmd_ready), 64'd0);
        end
        check("bp_accepted", 64'(acc_count - a0), 64'd3);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_pop_cycle", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("bp_ready_reassert", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        issue(1'b1, 12'd6, '0, '0);
        drain();
        check("bp_total", 64'(acc_count - a0), 64'd5);

        // Streaming reads.
        lat_check = 1'b1;
        issue(1'b1, AW'($urandom_range(0, 31)), '0, '0);
        f = last_acc_cyc;
        for (int i = 0; i < 99; i++) issue(1'b1, AW'($urandom_range(0, 31)), '0, '0);
        check("stream_span", 64'(last_acc_cyc - f), 64'd99);
        drain();
        lat_check = 1'b0;

        // Light sleep entry and wake.
        issue(1'b1, 12'd7, '0, '0);
        seen = 0;
        rise = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ram_ls) begin
                seen = 1;
                rise = cyc;
                break;
            end
        end
        check("ls_rise_seen", 64'(seen), 64'd1);
        check("ls_rise_delay", 64'(rise - last_pop_cyc), 64'(IDLE + 1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 12'd9;
        @(negedge clk);
        check("sleep_ls", 64'(ram_ls), 64'd1);
        check("sleep_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("wake_ls", 64'(ram_ls), 64'd0);
        check("wake_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("wake_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Random traffic with random response backpressure.
        running = 1'b1;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        cmd_valid = 1'b0;
                        repeat ($urandom_range(1, 8)) @(posedge clk);
                        #1;
                    end
                    issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
                          MW'($urandom_range(0, 15)));
                end
                cmd_valid = 1'b0;
                running   = 1'b0;
            end
            begin
                while (running) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        // Reset with two responses queued and one in flight.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) issue(1'b1, AW'(i), '0, '0);
        check("pre_reset_valid", 64'(rsp_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_ram_cs", 64'(ram_cs), 64'd0);
        check("arst_ram_ls", 64'(ram_ls), 64'd0);
        check("arst_cmd_ready", 64'(cmd_ready), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("stale_rsp_after_reset", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 12'd3, 32'hCAFE_F00D, 4'hF);
        issue(1'b1, 12'd3, '0, '0);
        drain();
        check("post_reset_data", 64'(last_rsp), 64'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ux607_dlm_ctrl.md
# ux607_dlm_ctrl

Upstream front-end for the DLM RAM macro wrapper. It converts a valid/ready command/response bus into single-cycle RAM accesses (`cs`/`addr`/`wem`/`din`) and captures the RAM's one-cycle read data into a response FIFO, so the requester can backpressure responses. It also drives the RAM light-sleep pin after a programmable idle period, with a one-cycle wake.

## Interface
- `AW`, default `UX607_DLM_RAM_AW`: RAM word-address width.
- `DW`, default `UX607_DLM_RAM_DW`: data width.
- `MW`, default `UX607_DLM_RAM_MW`: write-mask width, one bit per byte.
- `RSP_DEPTH`, default 3: response FIFO entries; minimum 2.
- `IDLE_LS_CYC`, default 16: idle cycles before `ram_ls` asserts; 0 disables light sleep.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_read` in 1: 1 = read, 0 = write.
- `cmd_addr` in AW: word address.
- `cmd_wdata` in DW: write data.
- `cmd_wmask` in MW: byte enables; ignored on reads.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid`.
- `rsp_rdata` out DW: read data; 0 for write responses.
- `ram_cs` out 1: RAM chip select.
- `ram_addr` out AW: RAM address.
- `ram_wem` out MW: RAM write mask.
- `ram_din` out DW: RAM write data.
- `ram_dout` in DW: RAM read data.
- `ram_ls` out 1: RAM light sleep.

## Operation
- Command acceptance:
  - Accept fires when `cmd_valid & cmd_ready`.
  - `cmd_ready = (state==ACTIVE) & (fifo_cnt + inflight < RSP_DEPTH)`.
- RAM drive (combinational, same cycle as accept):
  - `ram_cs` = accept.
  - `ram_addr` = `cmd_addr`.
  - `ram_wem` = `cmd_read ? 0 : cmd_wmask`.
  - `ram_din` = `cmd_wdata`.
  - Outside an accept, `ram_cs` = 0; `ram_wem`, `ram_addr` and `ram_din` are don't-care but are driven 0.
- In-flight tracking:
  - `inflight` and `inflight_rd` are registers, set on accept and otherwise cleared.
  - In the following cycle, the FIFO pushes `inflight_rd ? ram_dout : 0`.
  - `ram_dout` is only valid in the cycle immediately after a read access, so it must be captured then.
- Response FIFO:
  - Registered, in order, `RSP_DEPTH` entries.
  - `rsp_valid` = `fifo_cnt != 0`; `rsp_rdata` = head entry.
  - Push and pop in the same cycle leave `fifo_cnt` unchanged.
  - Pointers wrap modulo `RSP_DEPTH`; the width is `$clog2(RSP_DEPTH)` and must handle non-power-of-2 depths.
  - Overflow cannot occur because of the credit rule above.
- Light-sleep FSM, with states ACTIVE, SLEEP, WAKE:
  - ACTIVE: `idle_cnt` increments on every cycle with `!cmd_valid & !inflight & fifo_cnt==0`, saturating at `IDLE_LS_CYC`. Any other cycle clears it. Reaching `IDLE_LS_CYC` (when nonzero) moves to SLEEP.
  - SLEEP: `ram_ls` = 1 and `cmd_ready` = 0. `cmd_valid` moves to WAKE.
  - WAKE: `ram_ls` = 0 and `cmd_ready` = 0 for exactly one cycle, then ACTIVE with `idle_cnt` = 0.
  - `ram_ls` is registered: it is the decoded state, 1 only in SLEEP.
- Reset values:
  - Outputs: `cmd_ready` = 0 during reset, `rsp_valid` = 0, `rsp_rdata` = 0, `ram_cs` = 0, `ram_ls` = 0.
  - Internal: state = ACTIVE, `fifo_cnt` = 0, `inflight` = 0, `idle_cnt` = 0.
  - Reset asserted mid-transfer discards in-flight and queued responses.

## Timing
- Accept in cycle N:
  - RAM is accessed in N.
  - `ram_dout` is sampled at the end of N+1.
  - `rsp_valid` is first possible in N+2; fixed latency is 2 cycles with `rsp_ready` held high.
- With `RSP_DEPTH` ≥ 3 and `rsp_ready` = 1, the block sustains one command per cycle.
- With `rsp_ready` = 0, at most `RSP_DEPTH` commands are accepted before `cmd_ready` falls. `cmd_ready` reasserts the cycle after the first pop frees a credit.
- Wake penalty: a command arriving in SLEEP is accepted no earlier than 2 cycles later (one cycle in SLEEP seeing `cmd_valid`, one cycle in WAKE).

## Structure
- Shared package `ux607_dlm_ctrl_pkg`: FSM state enum (ACTIVE/SLEEP/WAKE) and the default `IDLE_LS_CYC` constant.
- One sub-module, `ux607_dlm_rsp_fifo`: parameterised DW×DEPTH synchronous FIFO with `cnt` output. The credit logic and FSM stay in the top level.
- `ux607_dlm_ctrl` instantiates beside the DLM RAM wrapper and connects `ram_*` to its `cs`/`addr`/`wem`/`din`/`dout`/`ls` pins.

## Test plan
- **Write then read:**
  - Stimulus: write addr 0x10, data 0xDEADBEEF, mask all-ones; then read addr 0x10.
  - Required: `ram_cs` pulses 1 cycle each; write response `rdata` = 0; read response 0xDEADBEEF arrives 2 cycles after its accept.
- **Partial write:**
  - Stimulus: write 0x11223344 to addr 5 with mask 4'b0101, over prior content 0xFFFFFFFF; then read addr 5.
  - Required: `ram_wem` = 4'b0101; read returns 0xFF22FF44.
- **Backpressure:**
  - Stimulus: `rsp_ready` = 0; issue 5 back-to-back reads.
  - Required: exactly 3 accepted, then `cmd_ready` = 0. Raise `rsp_ready`: responses come out in order, and the remaining 2 commands are accepted one cycle after credits free.
- **Streaming:**
  - Stimulus: 100 consecutive reads with `rsp_ready` = 1.
  - Required: `cmd_ready` never drops; 100 responses in order.
- **Light sleep:**
  - Stimulus: `IDLE_LS_CYC` = 4, bus idle.
  - Required: `ram_ls` rises after 4 idle cycles. A read arriving during SLEEP sees `ram_ls` fall next cycle, is accepted the cycle after, and returns correct data.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n` = 0 with 2 responses queued and 1 in flight.
  - Required: `rsp_valid`, `ram_cs` and `ram_ls` drop to 0 asynchronously; no stale response appears after release.
